// File: rtl/gene_net_pkg.sv
// Shared types and helpers for the gene-network trajectory checkers.
package gene_net_pkg;

    localparam int GENE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        DONE
    } fsm_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/attractor_detector_if.sv
// Controller <-> attractor detector signal bundle.
interface attractor_detector_if
    import gene_net_pkg::*;
#(
    parameter int WIDTH = GENE_W,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    localparam int PER_W = clog2(DEPTH + 1);

    logic             start;
    logic [WIDTH-1:0] init_val;
    logic             x_valid;
    logic [WIDTH-1:0] x;
    logic             busy;
    logic             found;
    logic             fixed_pt;
    logic [PER_W-1:0] period;
    logic [CNT_W-1:0] transient;
    logic [WIDTH-1:0] attractor_state;
    logic [WIDTH-1:0] init_tag;
    logic             timeout;

    modport master (
        output start, init_val, x_valid, x,
        input  busy, found, fixed_pt, period, transient, attractor_state, init_tag, timeout
    );

    modport slave (
        input  start, init_val, x_valid, x,
        output busy, found, fixed_pt, period, transient, attractor_state, init_tag, timeout
    );

endinterface

// File: rtl/attractor_detector_history_cam.sv
// Sample history shift register with parallel compare; hit_k is the
// 1-based lookback distance of the most recent matching entry.
module history_cam
    import gene_net_pkg::*;
#(
    parameter int WIDTH = GENE_W,
    parameter int DEPTH = 8,
    parameter int PER_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] x,
    output logic             hit,
    output logic [PER_W-1:0] hit_k
);

    logic [WIDTH-1:0] h_q [DEPTH];
    logic [WIDTH-1:0] h_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
        h_d     = h_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end else if (shift_en) begin
            h_d[0]     = x;
            valid_d[0] = 1'b1;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                h_d[i]     = h_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // Lowest index wins: the first entry found stays latched in hit_k.
    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit && valid_q[i] && (h_q[i] == x)) begin
                hit   = 1'b1;
                hit_k = PER_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q     <= '{default: '0};
            valid_q <= '0;
        end else begin
            h_q     <= h_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/attractor_detector.sv
// Detects the fixed point or limit cycle a gene-network trajectory enters,
// reporting period, transient length and the state at detection.
module attractor_detector
    import gene_net_pkg::*;
#(
    parameter int WIDTH     = GENE_W,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 8,
    parameter int MAX_STEPS = 255
) (
    input logic                 clk,
    input logic                 rst,
    attractor_detector_if.slave bus
);

    localparam int PER_W = clog2(DEPTH + 1);

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             found_q, found_d;
    logic             fixed_q, fixed_d;
    logic             timeout_q, timeout_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] transient_q, transient_d;
    logic [WIDTH-1:0] attr_q, attr_d;
    logic [WIDTH-1:0] tag_q, tag_d;

    logic             clear;
    logic             shift_en;
    logic             hit;
    logic [PER_W-1:0] hit_k;

    history_cam #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PER_W (PER_W)
    ) u_cam (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (shift_en),
        .x        (bus.x),
        .hit      (hit),
        .hit_k    (hit_k)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        found_d     = found_q;
        fixed_d     = fixed_q;
        timeout_d   = timeout_q;
        period_d    = period_q;
        transient_d = transient_q;
        attr_d      = attr_q;
        tag_d       = tag_q;
        clear       = 1'b0;
        shift_en    = 1'b0;

        if (bus.start) begin
            // Any sample arriving with start is deliberately discarded.
            clear       = 1'b1;
            step_d      = '0;
            found_d     = 1'b0;
            fixed_d     = 1'b0;
            timeout_d   = 1'b0;
            period_d    = '0;
            transient_d = '0;
            attr_d      = '0;
            tag_d       = bus.init_val;
            state_d     = TRACK;
        end else begin
            unique case (state_q)
                TRACK: begin
                    if (bus.x_valid) begin
                        if (hit) begin
                            found_d     = 1'b1;
                            period_d    = hit_k;
                            transient_d = step_q - CNT_W'(hit_k);
                            attr_d      = bus.x;
                            fixed_d     = (hit_k == PER_W'(1));
                            state_d     = DONE;
                        end else begin
                            shift_en = 1'b1;
                            step_d   = step_q + 1'b1;
                            if (step_q == CNT_W'(MAX_STEPS - 1)) begin
                                timeout_d = 1'b1;
                                state_d   = DONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            found_q     <= 1'b0;
            fixed_q     <= 1'b0;
            timeout_q   <= 1'b0;
            period_q    <= '0;
            transient_q <= '0;
            attr_q      <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            found_q     <= found_d;
            fixed_q     <= fixed_d;
            timeout_q   <= timeout_d;
            period_q    <= period_d;
            transient_q <= transient_d;
            attr_q      <= attr_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.busy            = (state_q == TRACK);
    assign bus.found           = found_q;
    assign bus.fixed_pt        = fixed_q;
    assign bus.period          = period_q;
    assign bus.transient       = transient_q;
    assign bus.attractor_state = attr_q;
    assign bus.init_tag        = tag_q;
    assign bus.timeout         = timeout_q;

endmodule

// File: tb/tb_attractor_detector.sv
// Bench for attractor_detector: vector table, corner sequences and random
// trajectories against a first-recurrence reference model.
module tb_attractor_detector;
    import gene_net_pkg::*;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int C  = 8;
    localparam int PW = clog2(D + 1);
    localparam int MAX_A = 255;
    localparam int MAX_B = 20;
    localparam int NSEQ  = 260;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    attractor_detector_if #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) if_a ();
    attractor_detector_if #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) if_b ();

    attractor_detector #(.WIDTH(W), .DEPTH(D), .CNT_W(C), .MAX_STEPS(MAX_A)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave)
    );
    attractor_detector #(.WIDTH(W), .DEPTH(D), .CNT_W(C), .MAX_STEPS(MAX_B)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave)
    );

    typedef struct packed {
        logic          busy;
        logic          found;
        logic          fixed_pt;
        logic [PW-1:0] period;
        logic [C-1:0]  transient;
        logic [W-1:0]  attr;
        logic [W-1:0]  tag;
        logic          timeout;
    } out_t;

    typedef struct {
        logic         st;
        logic [W-1:0] iv;
        logic         xv;
        logic [W-1:0] xx;
        out_t         exp;
    } vec_t;

    typedef struct {
        bit           found;
        bit           to;
        int           per;
        int           tr;
        int           endi;
        logic [W-1:0] st;
    } res_t;

    vec_t         tbl[$];
    logic [W-1:0] seq [NSEQ];
    int           n_checks = 0;
    int           n_fail   = 0;

    function automatic out_t mk(bit b, bit f, bit fx, int p, int tr,
                                logic [W-1:0] a, logic [W-1:0] tg, bit to);
        out_t o;
        o.busy = b; o.found = f; o.fixed_pt = fx;
        o.period = PW'(p); o.transient = C'(tr);
        o.attr = a; o.tag = tg; o.timeout = to;
        return o;
    endfunction

    function automatic out_t get_out(bit sel_b);
        out_t o;
        if (sel_b)
            o = '{if_b.busy, if_b.found, if_b.fixed_pt, if_b.period, if_b.transient,
                  if_b.attractor_state, if_b.init_tag, if_b.timeout};
        else
            o = '{if_a.busy, if_a.found, if_a.fixed_pt, if_a.period, if_a.transient,
                  if_a.attractor_state, if_a.init_tag, if_a.timeout};
        return o;
    endfunction

    function automatic void add(logic st, logic [W-1:0] iv, logic xv, logic [W-1:0] xx, out_t e);
        vec_t v;
        v.st = st; v.iv = iv; v.xv = xv; v.xx = xx; v.exp = e;
        tbl.push_back(v);
    endfunction

    // First recurrence within the last D samples, else timeout at sample maxs-1.
    function automatic res_t model(int n, int maxs);
        res_t r;
        r = '{found: 0, to: 0, per: 0, tr: 0, endi: -1, st: '0};
        for (int t = 0; t < n; t++) begin
            for (int k = 1; k <= D; k++) begin
                if (k <= t && seq[t] == seq[t-k]) begin
                    r.found = 1; r.per = k; r.tr = t - k; r.st = seq[t]; r.endi = t;
                    return r;
                end
            end
            if (t == maxs - 1) begin
                r.to = 1; r.endi = t;
                return r;
            end
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic st, logic [W-1:0] iv, logic xv, logic [W-1:0] xx);
        if_a.start = st; if_a.init_val = iv; if_a.x_valid = xv; if_a.x = xx;
        if_b.start = st; if_b.init_val = iv; if_b.x_valid = xv; if_b.x = xx;
        @(posedge clk);
        #1;
        if_a.start = 1'b0; if_a.x_valid = 1'b0;
        if_b.start = 1'b0; if_b.x_valid = 1'b0;
    endtask

    initial begin
        out_t r1;
        res_t ra, rb;
        int   last;
        logic [W-1:0] tag;

        drive(0, '0, 0, '0);
        drive(0, '0, 0, '0);
        chk("reset_a", get_out(0), '0);
        chk("reset_b", get_out(1), '0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, '0, 1, 8'h12);
        chk("idle_ignores_x", get_out(0), '0);

        // Fixed point
        add(1, 8'h05, 0, 8'h00, mk(1, 0, 0, 0, 0, 8'h00, 8'h05, 0));
        add(0, 8'h00, 1, 8'h05, mk(1, 0, 0, 0, 0, 8'h00, 8'h05, 0));
        add(0, 8'h00, 1, 8'h3A, mk(1, 0, 0, 0, 0, 8'h00, 8'h05, 0));
        add(0, 8'h00, 1, 8'h3A, mk(0, 1, 1, 1, 1, 8'h3A, 8'h05, 0));
        add(0, 8'h00, 1, 8'h77, mk(0, 1, 1, 1, 1, 8'h3A, 8'h05, 0));
        add(0, 8'h00, 0, 8'h00, mk(0, 1, 1, 1, 1, 8'h3A, 8'h05, 0));
        // Limit cycle of period 3
        add(1, 8'hAA, 0, 8'h00, mk(1, 0, 0, 0, 0, 8'h00, 8'hAA, 0));
        add(0, 8'h00, 1, 8'h01, mk(1, 0, 0, 0, 0, 8'h00, 8'hAA, 0));
        add(0, 8'h00, 1, 8'h02, mk(1, 0, 0, 0, 0, 8'h00, 8'hAA, 0));
        add(0, 8'h00, 1, 8'h10, mk(1, 0, 0, 0, 0, 8'h00, 8'hAA, 0));
        add(0, 8'h00, 1, 8'h20, mk(1, 0, 0, 0, 0, 8'h00, 8'hAA, 0));
        add(0, 8'h00, 1, 8'h40, mk(1, 0, 0, 0, 0, 8'h00, 8'hAA, 0));
        add(0, 8'h00, 1, 8'h10, mk(0, 1, 0, 3, 2, 8'h10, 8'hAA, 0));
        // Period equal to history depth
        add(1, 8'h3C, 0, 8'h00, mk(1, 0, 0, 0, 0, 8'h00, 8'h3C, 0));
        for (int i = 0; i < D; i++)
            add(0, 8'h00, 1, W'(i), mk(1, 0, 0, 0, 0, 8'h00, 8'h3C, 0));
        add(0, 8'h00, 1, 8'h00, mk(0, 1, 0, 8, 0, 8'h00, 8'h3C, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].iv, tbl[i].xv, tbl[i].xx);
            chk($sformatf("vec%0d", i), get_out(0), tbl[i].exp);
        end

        // Period 9 exceeds the history; the short-timeout instance gives up
        drive(1, 8'h5A, 0, 8'h00);
        for (int i = 0; i < MAX_B; i++) begin
            drive(0, 8'h00, 1, W'(i % 9));
            if (i == MAX_B - 2)
                chk("p9_before_timeout", get_out(1), mk(1, 0, 0, 0, 0, 8'h00, 8'h5A, 0));
        end
        chk("p9_timeout", get_out(1), mk(0, 0, 0, 0, 0, 8'h00, 8'h5A, 1));
        chk("p9_still_tracking", get_out(0), mk(1, 0, 0, 0, 0, 8'h00, 8'h5A, 0));

        // Gapped samples, then restart with a concurrent sample
        drive(1, 8'h11, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h01);
        drive(0, 8'h00, 0, 8'h00);
        chk("gap_hold", get_out(0), mk(1, 0, 0, 0, 0, 8'h00, 8'h11, 0));
        drive(0, 8'h00, 1, 8'h02);
        drive(0, 8'h00, 0, 8'h00);
        drive(0, 8'h00, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h03);
        drive(1, 8'h22, 1, 8'h03);
        chk("restart", get_out(0), mk(1, 0, 0, 0, 0, 8'h00, 8'h22, 0));
        drive(0, 8'h00, 1, 8'h03);
        chk("restart_history_cleared", get_out(0), mk(1, 0, 0, 0, 0, 8'h00, 8'h22, 0));
        drive(0, 8'h00, 1, 8'h09);
        drive(0, 8'h00, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h03);
        chk("restart_result", get_out(0), mk(0, 1, 0, 2, 0, 8'h03, 8'h22, 0));

        // Asynchronous reset while in DONE
        #2 rst = 1'b0;
        #1;
        chk("async_reset_a", get_out(0), '0);
        chk("async_reset_b", get_out(1), '0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 1, 8'h05);
        chk("post_reset_idle", get_out(0), '0);

        // Identical restart from DONE
        r1 = mk(0, 1, 1, 1, 1, 8'h3A, 8'h05, 0);
        drive(1, 8'h05, 0, 8'h00);
        drive(0, 8'h00, 1, 8'h05); drive(0, 8'h00, 1, 8'h3A); drive(0, 8'h00, 1, 8'h3A);
        chk("same_run1", get_out(0), r1);
        drive(1, 8'h05, 0, 8'h00);
        chk("same_after_start", get_out(0), mk(1, 0, 0, 0, 0, 8'h00, 8'h05, 0));
        drive(0, 8'h00, 1, 8'h05); drive(0, 8'h00, 1, 8'h3A); drive(0, 8'h00, 1, 8'h3A);
        chk("same_run2", get_out(0), r1);

        // Random trajectories
        for (int run = 0; run < 40; run++) begin
            if ($urandom_range(0, 1) == 0) begin
                int alpha = int'($urandom_range(2, 80));
                for (int i = 0; i < NSEQ; i++) seq[i] = W'($urandom_range(0, alpha - 1));
            end else begin
                int per  = int'($urandom_range(1, 16));
                int pre  = int'($urandom_range(0, 12));
                int base = int'($urandom_range(0, 100));
                for (int i = 0; i < NSEQ; i++)
                    seq[i] = (i < pre) ? W'(200 + i) : W'(base + ((i - pre) % per));
            end
            ra  = model(NSEQ, MAX_A);
            rb  = model(NSEQ, MAX_B);
            tag = W'($urandom);
            last = ((ra.endi > rb.endi) ? ra.endi : rb.endi) + 2;
            drive(1, tag, 0, 8'h00);
            for (int i = 0; i <= last; i++) begin
                if ($urandom_range(0, 3) == 0) drive(0, 8'h00, 0, 8'h00);
                drive(0, 8'h00, 1, seq[i]);
                chk($sformatf("rnd%0d_busy_a_%0d", run, i), 32'(if_a.busy), 32'(i < ra.endi));
                chk($sformatf("rnd%0d_busy_b_%0d", run, i), 32'(if_b.busy), 32'(i < rb.endi));
            end
            chk($sformatf("rnd%0d_a", run), get_out(0),
                mk(0, ra.found, ra.found && ra.per == 1, ra.per, ra.tr, ra.st, tag, ra.to));
            chk($sformatf("rnd%0d_b", run), get_out(1),
                mk(0, rb.found, rb.found && rb.per == 1, rb.per, rb.tr, rb.st, tag, rb.to));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
